// File: rtl/ifu_fetch_queue.sv
// Fetch response queue: issues the PC generator's fetch address on the instruction bus,
// buffers returned words with their PCs and presents them to decode in order.
module ifu_fetch_queue #(
    parameter int               XLEN       = 32,
    parameter int               DEPTH      = 4,
    parameter logic [XLEN-1:0]  RESET_ADDR = '0
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [XLEN-1:0] i_fetch_addr,
    input  logic            i_jump,
    output logic            o_pc_vld,
    output logic            o_fetch_vld,
    output logic            o_fifo_empty,
    output logic [XLEN-1:0] o_pc_goback,
    output logic            o_ibus_req,
    output logic [XLEN-1:0] o_ibus_addr,
    input  logic            i_ibus_gnt,
    input  logic            i_ibus_rvld,
    input  logic [XLEN-1:0] i_ibus_rdata,
    output logic            o_inst_vld,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_inst_rdy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            outstanding_q, outstanding_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] goback_q, goback_d;

    logic            empty;
    logic            resp_done;
    logic            push;
    logic            pop;
    logic            outstanding_eff;
    logic            accept;
    logic [CW:0]     count_eff;

    assign empty        = (count_q == '0);
    assign o_fifo_empty = empty;
    assign o_inst_vld   = ~empty;
    assign o_inst       = empty ? '0 : inst_mem_q[rd_ptr_q];
    assign o_inst_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];
    assign o_pc_goback  = goback_q;
    assign o_ibus_addr  = i_fetch_addr;

    // A redirect suppresses both the decode pop and the push of any returning word.
    assign resp_done = i_ibus_rvld & outstanding_q;
    assign push      = resp_done & ~drop_q & ~i_jump;
    assign pop       = i_rstn & ~empty & i_inst_rdy & ~i_jump;

    // The returning word of a new request needs a free slot, so a word landing this
    // cycle counts as occupied; a redirect frees the whole FIFO.
    assign outstanding_eff = outstanding_q & ~i_ibus_rvld;
    always_comb begin
        count_eff = '0;
        if (!i_jump) begin
            count_eff = {1'b0, count_q} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, push};
        end
    end

    assign o_ibus_req  = i_rstn & ~outstanding_eff & (count_eff < DEPTH_C);
    assign accept      = o_ibus_req & i_ibus_gnt;
    assign o_pc_vld    = accept;
    assign o_fetch_vld = pop;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        req_pc_d      = req_pc_q;
        goback_d      = goback_q;

        if (accept) begin
            outstanding_d = 1'b1;
            req_pc_d      = i_fetch_addr;
            goback_d      = i_fetch_addr + XLEN'(4);
        end else if (i_ibus_rvld) begin
            outstanding_d = 1'b0;
        end

        // Only a request still in flight after the redirect needs its word discarded.
        if (resp_done) begin
            drop_d = 1'b0;
        end else if (i_jump && outstanding_q) begin
            drop_d = 1'b1;
        end

        if (i_jump) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            req_pc_q      <= '0;
            goback_q      <= RESET_ADDR;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            req_pc_q      <= req_pc_d;
            goback_q      <= goback_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn && push) begin
            inst_mem_q[wr_ptr_q] <= i_ibus_rdata;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule
